pipe_sequencer: RTL
===================

// Module: pipe_sequencer
// PURPOSE
//   Central advance/stall controller for the 5-stage 16-bit pipeline (IF/ID/EX/MEM/WB).
//   Replaces the per-stage PAUSE/step_btn_down gating with a single run/halt/step FSM.
//   Inserts one-cycle load-use bubbles between ID and EX.
//   Keeps saturating cycle and stall counters for the debug display.
//   Sits beside clockdiv/debouncer and drives the enables of the PC, IFID, IDEX, EXMEM and MEMWB registers.
// PARAMETERS
//   CNT_W        16  width of cycle_cnt and stall_cnt
//   STEP_CYCLES  1   pipeline advances per step press (>=1)
// PORTS
//   CLK           in   1      system clock; all state on posedge
//   RST           in   1      synchronous reset, active-high
//   tick          in   1      pipeline-clock enable, one CLK-wide pulse per PCLK period
//   pause         in   1      level; 1 = halt/single-step mode
//   step_pulse    in   1      one-cycle debounced step press (btn_down)
//   id_rs         in   4      ID-stage source reg (IFID insn[11:8])
//   id_rt         in   4      ID-stage source reg (IFID insn[7:4])
//   id_uses_rt    in   1      ID instruction reads rt
//   idex_memread  in   1      EX-stage instruction is a load
//   idex_wa       in   4      EX-stage dest reg (after regdst select)
//   pc_en         out  1      advance PC
//   ifid_en       out  1      load IFID
//   idex_bubble   out  1      load IDEX with all control fields zeroed
//   pipe_en       out  1      advance IDEX, EXMEM and MEMWB
//   state         out  2      00 RUN, 01 HALT, 10 STEP
//   step_busy     out  1      1 while state==STEP
//   cycle_cnt     out  CNT_W  pipeline advances since reset, saturating
//   stall_cnt     out  CNT_W  bubbles inserted since reset, saturating
// BEHAVIOUR
//   Reset (RST=1): state<=RUN if pause==0, else HALT; remaining<=0; counters<=0.
//     All enable outputs are 0 during any cycle with RST=1, regardless of tick.
//   adv = ~RST & tick & (state==RUN | state==STEP); decided from the registered state.
//   hazard = idex_memread & ((idex_wa==id_rs) | (id_uses_rt & idex_wa==id_rt)).
//     Comparison is full 4-bit; register 0 is not special.
//   Outputs (combinational from registered state and inputs):
//     pipe_en = adv; pc_en = ifid_en = adv & ~hazard; idex_bubble = adv & hazard.
//   FSM:
//     RUN:  pause=1 -> HALT. A tick in the same cycle still advances.
//     HALT: pause=0 -> RUN (priority over step).
//           Else step_pulse -> STEP with remaining<=STEP_CYCLES.
//           The step_pulse cycle itself never advances.
//     STEP: pause=0 -> RUN; remaining is abandoned.
//           Else on tick: remaining<=remaining-1; if remaining==1 -> HALT.
//           step_pulse in STEP is ignored; presses are not queued.
//   A stalled advance still counts as one step cycle.
//   Counters: cycle_cnt+=1 on adv; stall_cnt+=1 on adv&hazard.
//     Both hold at all-ones; there is no wrap.
//   RST mid-STEP: remaining is cleared and no pending advance survives.
//   Latency: enables are asserted in the same CLK cycle as the qualifying tick; no extra register stage.
// TESTING
//   1 RST, pause=0, tick every 4 CLK, no hazard, 3 ticks
//     -> pipe_en=pc_en=1 exactly on each tick; cycle_cnt=3; state=00.
//   2 pause=1 (HALT), step_pulse once, STEP_CYCLES=1, then 5 ticks
//     -> exactly one pipe_en, on the first tick after the press; state 01->10->01; cycle_cnt=1.
//   3 RUN, idex_memread=1, idex_wa=3, id_rs=3, tick
//     -> pipe_en=1, pc_en=ifid_en=0, idex_bubble=1, stall_cnt=1.
//   4 same as 3 but id_rs=5, id_rt=3, id_uses_rt=0
//     -> no hazard: idex_bubble=0, pc_en=1.
//     Repeat with id_uses_rt=1 -> bubble.
//   5 STEP_CYCLES=3, press in HALT; press again after 1 tick; pause=0 after 2 ticks
//     -> second press ignored; state=00 on the cycle after pause falls.
//   6 RST asserted mid-STEP (remaining=2) together with a tick, CNT_W=4
//     -> all enables 0 that cycle; counters 0.
//     Afterwards, 20 ticks in RUN -> cycle_cnt=15 (saturated).

Source files
------------

// File: rtl/pipe_sequencer_if.sv
// Control bundle between the pipeline sequencer and the rest of the datapath:
// timing/step inputs, hazard-detect operands, stage enables and debug counters.
interface pipe_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             tick;
    logic             pause;
    logic             step_pulse;
    logic [3:0]       id_rs;
    logic [3:0]       id_rt;
    logic             id_uses_rt;
    logic             idex_memread;
    logic [3:0]       idex_wa;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_bubble;
    logic             pipe_en;
    logic [1:0]       state;
    logic             step_busy;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;

    // Datapath/board side: drives timing and hazard operands, consumes enables
    modport master (
        output tick, pause, step_pulse, id_rs, id_rt, id_uses_rt, idex_memread, idex_wa,
        input  pc_en, ifid_en, idex_bubble, pipe_en, state, step_busy, cycle_cnt, stall_cnt
    );

    // Sequencer side
    modport slave (
        input  tick, pause, step_pulse, id_rs, id_rt, id_uses_rt, idex_memread, idex_wa,
        output pc_en, ifid_en, idex_bubble, pipe_en, state, step_busy, cycle_cnt, stall_cnt
    );
endinterface

// File: rtl/pipe_sequencer.sv
// Central advance/stall controller for the 5-stage pipeline.
// A run/halt/step FSM decides when a pipeline tick may advance the stages,
// a load-use check turns such an advance into an ID->EX bubble, and two
// saturating counters record advances and bubbles for the debug display.
module pipe_sequencer #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned STEP_CYCLES = 1
) (
    input  logic            CLK,
    input  logic            RST,
    pipe_sequencer_if.slave bus
);
    localparam int unsigned REM_W = (STEP_CYCLES < 2) ? 1 : $clog2(STEP_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HALT = 2'b01,
        ST_STEP = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [REM_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic hazard;
    logic adv;
    logic rs_match;
    logic rt_match;

    // Load-use hazard: EX holds a load whose destination is read by the ID instruction
    always_comb begin
        rs_match = (bus.idex_wa == bus.id_rs);
        rt_match = bus.id_uses_rt & (bus.idex_wa == bus.id_rt);
        hazard   = bus.idex_memread & (rs_match | rt_match);
    end

    // Advance qualification from the registered state; reset forces every enable low
    always_comb begin
        adv = ~RST & bus.tick & ((state_q == ST_RUN) | (state_q == ST_STEP));
    end

    assign bus.pipe_en     = adv;
    assign bus.pc_en       = adv & ~hazard;
    assign bus.ifid_en     = adv & ~hazard;
    assign bus.idex_bubble = adv & hazard;
    assign bus.state       = state_q;
    assign bus.step_busy   = (state_q == ST_STEP);
    assign bus.cycle_cnt   = cycle_cnt_q;
    assign bus.stall_cnt   = stall_cnt_q;

    // Run/halt/step next-state; a stalled advance still consumes a step cycle
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        unique case (state_q)
            ST_RUN: begin
                if (bus.pause) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!bus.pause) begin
                    state_d = ST_RUN;
                end else if (bus.step_pulse) begin
                    state_d     = ST_STEP;
                    remaining_d = REM_W'(STEP_CYCLES);
                end
            end
            ST_STEP: begin
                if (!bus.pause) begin
                    state_d     = ST_RUN;
                    remaining_d = '0;
                end else if (bus.tick) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == REM_W'(1)) begin
                        state_d = ST_HALT;
                    end
                end
            end
            default: begin
                state_d     = ST_HALT;
                remaining_d = '0;
            end
        endcase
    end

    // Saturating advance and bubble counters
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (adv && (cycle_cnt_q != '1)) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
        if (adv && hazard && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset picks RUN or HALT from the live pause level
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= bus.pause ? ST_HALT : ST_RUN;
            remaining_q <= '0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule
